// File: rtl/axi_lite_reg_bridge.sv
// AXI4-Lite slave endpoint that turns bus transactions into single-cycle register strobes.
// One transaction in flight at a time; reads and writes alternate under contention.
module axi_lite_reg_bridge #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned REG_ADDR_BITS = 12
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [ADDR_WIDTH-1:0]     i_s_axi_awaddr,
    input  logic [2:0]                i_s_axi_awprot,
    input  logic                      i_s_axi_awvalid,
    output logic                      o_s_axi_awready,
    input  logic [DATA_WIDTH-1:0]     i_s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   i_s_axi_wstrb,
    input  logic                      i_s_axi_wvalid,
    output logic                      o_s_axi_wready,
    output logic                      o_s_axi_bvalid,
    input  logic                      i_s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]     i_s_axi_araddr,
    input  logic [2:0]                i_s_axi_arprot,
    input  logic                      i_s_axi_arvalid,
    output logic                      o_s_axi_arready,
    output logic [DATA_WIDTH-1:0]     o_s_axi_rdata,
    output logic                      o_s_axi_rvalid,
    input  logic                      i_s_axi_rready,
    output logic                      o_reg_wen,
    output logic                      o_reg_ren,
    output logic [REG_ADDR_BITS-1:0]  o_reg_addr,
    output logic [DATA_WIDTH-1:0]     o_reg_wdata,
    output logic [DATA_WIDTH/8-1:0]   o_reg_wstrb,
    input  logic [DATA_WIDTH-1:0]     i_reg_rdata
);

    localparam int unsigned StrbWidth = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        StIdle,
        StWWaitD,
        StWWaitA,
        StWExec,
        StWResp,
        StRExec,
        StRWait,
        StRResp
    } state_e;

    state_e                   state_q, state_d;
    logic                     prio_read_q, prio_read_d;
    logic [REG_ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [StrbWidth-1:0]     wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;

    logic                     rd_sel;
    logic                     aw_rdy, w_rdy, ar_rdy;
    logic [REG_ADDR_BITS-1:0] awaddr_word, araddr_word;

    // Offsets outside the window alias; the interconnect has already decoded the slave.
    assign awaddr_word = {i_s_axi_awaddr[REG_ADDR_BITS-1:2], 2'b00};
    assign araddr_word = {i_s_axi_araddr[REG_ADDR_BITS-1:2], 2'b00};

    logic unused_inputs;
    assign unused_inputs = ^{i_s_axi_awprot, i_s_axi_arprot,
                             i_s_axi_awaddr[ADDR_WIDTH-1:REG_ADDR_BITS], i_s_axi_awaddr[1:0],
                             i_s_axi_araddr[ADDR_WIDTH-1:REG_ADDR_BITS], i_s_axi_araddr[1:0]};

    always_comb begin
        state_d     = state_q;
        prio_read_d = prio_read_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        aw_rdy      = 1'b0;
        w_rdy       = 1'b0;
        ar_rdy      = 1'b0;
        rd_sel      = i_s_axi_arvalid &
                      (~(i_s_axi_awvalid | i_s_axi_wvalid) | prio_read_q);

        case (state_q)
            StIdle: begin
                ar_rdy = rd_sel;
                aw_rdy = ~rd_sel;
                w_rdy  = ~rd_sel;
                if (rd_sel) begin
                    addr_d  = araddr_word;
                    state_d = StRExec;
                end else begin
                    if (i_s_axi_awvalid) begin
                        addr_d = awaddr_word;
                    end
                    if (i_s_axi_wvalid) begin
                        wdata_d = i_s_axi_wdata;
                        wstrb_d = i_s_axi_wstrb;
                    end
                    if (i_s_axi_awvalid && i_s_axi_wvalid) begin
                        state_d = StWExec;
                    end else if (i_s_axi_awvalid) begin
                        state_d = StWWaitD;
                    end else if (i_s_axi_wvalid) begin
                        state_d = StWWaitA;
                    end
                end
            end
            StWWaitD: begin
                w_rdy = 1'b1;
                if (i_s_axi_wvalid) begin
                    wdata_d = i_s_axi_wdata;
                    wstrb_d = i_s_axi_wstrb;
                    state_d = StWExec;
                end
            end
            StWWaitA: begin
                aw_rdy = 1'b1;
                if (i_s_axi_awvalid) begin
                    addr_d  = awaddr_word;
                    state_d = StWExec;
                end
            end
            StWExec: state_d = StWResp;
            StWResp: begin
                if (i_s_axi_bready) begin
                    prio_read_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StRExec: state_d = StRWait;
            StRWait: begin
                // Register file presents data the cycle after the read strobe.
                rdata_d = i_reg_rdata;
                state_d = StRResp;
            end
            StRResp: begin
                if (i_s_axi_rready) begin
                    prio_read_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StIdle;
            prio_read_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            prio_read_q <= prio_read_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
        end
    end

    // Readies are held low while reset is asserted so no handshake is ever advertised.
    assign o_s_axi_awready = aw_rdy & resetn;
    assign o_s_axi_wready  = w_rdy & resetn;
    assign o_s_axi_arready = ar_rdy & resetn;
    assign o_s_axi_bvalid  = (state_q == StWResp);
    assign o_s_axi_rvalid  = (state_q == StRResp);
    assign o_s_axi_rdata   = rdata_q;
    assign o_reg_wen       = (state_q == StWExec);
    assign o_reg_ren       = (state_q == StRExec);
    assign o_reg_addr      = addr_q;
    assign o_reg_wdata     = wdata_q;
    assign o_reg_wstrb     = wstrb_q;

endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// Scoreboard bench for axi_lite_reg_bridge: stimulus queues expectations, a negedge monitor
// pops and compares them as the bridge presents strobes and responses.
module tb_axi_lite_reg_bridge;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned RB = 12;
    localparam int unsigned SW = DW / 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, wvalid, arvalid, bready, rready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          awready, wready, arready, bvalid, rvalid;
    logic [DW-1:0] rdata;
    logic          reg_wen, reg_ren;
    logic [RB-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic [SW-1:0] reg_wstrb;
    logic [DW-1:0] reg_rdata;

    always #5 clk = ~clk;

    axi_lite_reg_bridge #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .REG_ADDR_BITS(RB)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .i_s_axi_awaddr (awaddr),
        .i_s_axi_awprot (3'b000),
        .i_s_axi_awvalid(awvalid),
        .o_s_axi_awready(awready),
        .i_s_axi_wdata  (wdata),
        .i_s_axi_wstrb  (wstrb),
        .i_s_axi_wvalid (wvalid),
        .o_s_axi_wready (wready),
        .o_s_axi_bvalid (bvalid),
        .i_s_axi_bready (bready),
        .i_s_axi_araddr (araddr),
        .i_s_axi_arprot (3'b000),
        .i_s_axi_arvalid(arvalid),
        .o_s_axi_arready(arready),
        .o_s_axi_rdata  (rdata),
        .o_s_axi_rvalid (rvalid),
        .i_s_axi_rready (rready),
        .o_reg_wen      (reg_wen),
        .o_reg_ren      (reg_ren),
        .o_reg_addr     (reg_addr),
        .o_reg_wdata    (reg_wdata),
        .o_reg_wstrb    (reg_wstrb),
        .i_reg_rdata    (reg_rdata)
    );

    typedef struct packed {
        logic [RB-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        int            cyc;
    } wr_exp_t;
    typedef struct packed {
        logic [RB-1:0] addr;
        int            cyc;
    } rd_exp_t;
    typedef struct packed {
        logic [DW-1:0] data;
        int            cyc;
    } rsp_exp_t;
    typedef struct packed {
        logic [63:0] act;
        logic [63:0] exp;
    } chk_t;

    wr_exp_t       wr_q[$];
    rd_exp_t       ren_q[$];
    rsp_exp_t      rv_q[$];
    int            b_q[$];
    int            op_q[$];
    logic [DW-1:0] model_q[$];
    string         chk_name_q[$];
    chk_t          chk_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Register file model: returns the next queued word the cycle after a read strobe.
    always @(posedge clk) begin
        if (reg_ren && model_q.size() > 0) reg_rdata <= model_q.pop_front();
        else                               reg_rdata <= 32'hBAD0_BAD0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    wr_exp_t  m_we;
    rd_exp_t  m_re;
    rsp_exp_t m_rs;
    chk_t     m_c;
    int       m_bc;
    logic     bvalid_p, bready_p, rvalid_p, rready_p;
    logic [DW-1:0] rdata_p;

    initial begin
        bvalid_p = 1'b0; bready_p = 1'b0; rvalid_p = 1'b0; rready_p = 1'b0; rdata_p = '0;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            while (chk_q.size() > 0) begin
                m_c = chk_q.pop_front();
                check(chk_name_q.pop_front(), m_c.act, m_c.exp);
            end
            if (!resetn) begin
                bvalid_p = 1'b0; bready_p = 1'b0; rvalid_p = 1'b0; rready_p = 1'b0;
            end else begin
                if (reg_wen || reg_ren) check("wen_ren_exclusive", 64'(reg_wen & reg_ren), 64'd0);
                if (reg_wen) begin
                    if (wr_q.size() == 0) check("wen_unexpected", 64'(wr_q.size()), 64'd1);
                    else begin
                        m_we = wr_q.pop_front();
                        check("wen_addr", 64'(reg_addr), 64'(m_we.addr));
                        check("wen_wdata", 64'(reg_wdata), 64'(m_we.data));
                        check("wen_wstrb", 64'(reg_wstrb), 64'(m_we.strb));
                        if (m_we.cyc >= 0) check("wen_cycle", 64'(cyc), 64'(m_we.cyc));
                    end
                    if (op_q.size() == 0) check("op_unexpected", 64'(op_q.size()), 64'd1);
                    else check("op_order_write", 64'(op_q.pop_front()), 64'd0);
                end
                if (reg_ren) begin
                    if (ren_q.size() == 0) check("ren_unexpected", 64'(ren_q.size()), 64'd1);
                    else begin
                        m_re = ren_q.pop_front();
                        check("ren_addr", 64'(reg_addr), 64'(m_re.addr));
                        if (m_re.cyc >= 0) check("ren_cycle", 64'(cyc), 64'(m_re.cyc));
                    end
                    if (op_q.size() == 0) check("op_unexpected", 64'(op_q.size()), 64'd1);
                    else check("op_order_read", 64'(op_q.pop_front()), 64'd1);
                end
                if (bvalid && !bvalid_p) begin
                    if (b_q.size() == 0) check("bvalid_unexpected", 64'(b_q.size()), 64'd1);
                    else begin
                        m_bc = b_q.pop_front();
                        if (m_bc >= 0) check("bvalid_cycle", 64'(cyc), 64'(m_bc));
                    end
                end
                if (bvalid_p && !bready_p) check("bvalid_hold", 64'(bvalid), 64'd1);
                if (rvalid && !rvalid_p) begin
                    if (rv_q.size() == 0) check("rvalid_unexpected", 64'(rv_q.size()), 64'd1);
                    else begin
                        m_rs = rv_q.pop_front();
                        check("rdata", 64'(rdata), 64'(m_rs.data));
                        if (m_rs.cyc >= 0) check("rvalid_cycle", 64'(cyc), 64'(m_rs.cyc));
                    end
                end
                if (rvalid_p && !rready_p) begin
                    check("rvalid_hold", 64'(rvalid), 64'd1);
                    check("rdata_hold", 64'(rdata), 64'(rdata_p));
                end
                bvalid_p = bvalid; bready_p = bready;
                rvalid_p = rvalid; rready_p = rready; rdata_p = rdata;
            end
        end
    end

    // Stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_t c;
        c.act = act;
        c.exp = exp;
        chk_name_q.push_back(name);
        chk_q.push_back(c);
    endtask

    // cw: expected wen cycle (-1 = unchecked); bvalid expected one cycle later.
    task automatic exp_write(input logic [RB-1:0] a, input logic [DW-1:0] d,
                             input logic [SW-1:0] s, input int cw);
        wr_exp_t e;
        e.addr = a; e.data = d; e.strb = s; e.cyc = cw;
        wr_q.push_back(e);
        b_q.push_back((cw < 0) ? -1 : cw + 1);
        op_q.push_back(0);
    endtask

    // cr: expected ren cycle (-1 = unchecked); rvalid expected two cycles later.
    task automatic exp_read(input logic [RB-1:0] a, input logic [DW-1:0] d, input int cr,
                            input bit resp);
        rd_exp_t  r;
        rsp_exp_t s;
        r.addr = a; r.cyc = cr;
        ren_q.push_back(r);
        model_q.push_back(d);
        op_q.push_back(1);
        if (resp) begin
            s.data = d; s.cyc = (cr < 0) ? -1 : cr + 2;
            rv_q.push_back(s);
        end
    endtask

    task automatic wait_out(input int sel, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            case (sel)
                3:       seen = bvalid;
                4:       seen = rvalid;
                default: seen = 1'b0;
            endcase
        end
        if (!seen) push_chk(name, 64'(seen), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required $finish");
        $fatal(1);
    end

    initial begin
        int k;
        resetn = 1'b0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;

        // Reset values
        repeat (3) tick();
        @(negedge clk);
        push_chk("rst_ready", 64'({awready, wready, arready}), 64'd0);
        push_chk("rst_valid", 64'({bvalid, rvalid, reg_wen, reg_ren}), 64'd0);
        push_chk("rst_addr", 64'(reg_addr), 64'd0);
        push_chk("rst_wdata_wstrb", 64'({reg_wdata, reg_wstrb}), 64'd0);
        push_chk("rst_rdata", 64'(rdata), 64'd0);
        tick();
        resetn = 1'b1;

        // AW and W together
        tick();
        awaddr = 32'h0200_2008; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        exp_write(12'h008, 32'hDEAD_BEEF, 4'hF, cyc + 2);
        @(negedge clk);
        push_chk("aw_w_ready", 64'({awready, wready}), 64'd3);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        wait_out(3, "timeout_bvalid_t1");
        tick();
        @(negedge clk);
        push_chk("bvalid_clear", 64'(bvalid), 64'd0);

        // W four cycles before AW
        tick();
        wvalid = 1'b1; wdata = 32'hCAFE_0001; wstrb = 4'h3;
        tick();
        wvalid = 1'b0; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            push_chk("wwait_a_ready", 64'({awready, wready, reg_wen}), 64'd4);
            tick();
        end
        awaddr = 32'h0000_0004; awvalid = 1'b1;
        exp_write(12'h004, 32'hCAFE_0001, 4'h3, cyc + 2);
        tick();
        awvalid = 1'b0; awaddr = 32'hFFFF_FFFC;
        wait_out(3, "timeout_bvalid_t2");
        tick();

        // AW two cycles before W
        tick();
        awaddr = 32'h0000_0010; awvalid = 1'b1;
        tick();
        awvalid = 1'b0; awaddr = 32'hFFFF_FFFC;
        @(negedge clk);
        push_chk("wwait_d_ready", 64'({awready, wready, reg_wen}), 64'd2);
        tick();
        wvalid = 1'b1; wdata = 32'h0BAD_F00D; wstrb = 4'hC;
        exp_write(12'h010, 32'h0BAD_F00D, 4'hC, cyc + 2);
        tick();
        wvalid = 1'b0;
        wait_out(3, "timeout_bvalid_t3");
        tick();

        // Read with R backpressure
        tick();
        rready = 1'b0;
        araddr = 32'h0000_000C; arvalid = 1'b1;
        exp_read(12'h00C, 32'h1234_5678, cyc + 2, 1'b1);
        tick();
        arvalid = 1'b0;
        wait_out(4, "timeout_rvalid_t4");
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            push_chk("r_stall", 64'({rvalid, rdata}), 64'({1'b1, 32'h1234_5678}));
        end
        tick();
        rready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        push_chk("rvalid_clear", 64'(rvalid), 64'd0);

        // B backpressure with a competing read pending
        tick();
        bready = 1'b0;
        awaddr = 32'h0000_0020; wdata = 32'h1111_2222; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h0000_0014; arvalid = 1'b1;
        exp_write(12'h020, 32'h1111_2222, 4'hF, cyc + 2);
        @(negedge clk);
        push_chk("arb_write_first", 64'({awready, wready, arready}), 64'd6);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        wait_out(3, "timeout_bvalid_t5");
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            push_chk("b_stall", 64'({bvalid, arready}), 64'd2);
        end
        tick();
        bready = 1'b1;
        exp_read(12'h014, 32'h5555_AAAA, cyc + 3, 1'b1);
        @(negedge clk);
        tick();
        @(negedge clk);
        push_chk("ar_after_b", 64'({arready, awready}), 64'd2);
        tick();
        arvalid = 1'b0;
        wait_out(4, "timeout_rvalid_t5");
        tick();

        // All valids held from reset: writes and reads must alternate
        tick();
        resetn = 1'b0;
        awaddr = 32'h0000_0030; wdata = 32'hA5A5_0000; wstrb = 4'hF;
        araddr = 32'h0000_0034;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        tick();
        resetn = 1'b1;
        k = cyc + 1;
        exp_write(12'h030, 32'hA5A5_0000, 4'hF, k + 1);
        exp_read(12'h034, 32'h0101_0101, k + 4, 1'b1);
        exp_write(12'h030, 32'hA5A5_0000, 4'hF, k + 8);
        exp_read(12'h034, 32'h0202_0202, k + 11, 1'b1);
        exp_write(12'h030, 32'hA5A5_0000, 4'hF, k + 15);
        repeat (15) tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        wait_out(3, "timeout_bvalid_t6");
        tick();

        // Reset while waiting for register read data
        tick();
        araddr = 32'h0000_0018; arvalid = 1'b1;
        exp_read(12'h018, 32'h7777_7777, cyc + 2, 1'b0);
        tick();
        arvalid = 1'b0;
        tick();
        resetn = 1'b0;
        tick();
        @(negedge clk);
        push_chk("abort_valid", 64'({rvalid, bvalid, reg_wen, reg_ren}), 64'd0);
        push_chk("abort_ready", 64'({awready, wready, arready}), 64'd0);
        push_chk("abort_addr_rdata", 64'({reg_addr, rdata}), 64'd0);
        tick();
        resetn = 1'b1;
        tick();
        awaddr = 32'h0000_001C; wdata = 32'h600D_600D; wstrb = 4'h5;
        awvalid = 1'b1; wvalid = 1'b1;
        exp_write(12'h01C, 32'h600D_600D, 4'h5, cyc + 2);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        wait_out(3, "timeout_bvalid_t7");
        tick();

        repeat (4) tick();
        push_chk("queues_drained",
                 64'(wr_q.size() + ren_q.size() + b_q.size() + rv_q.size() + op_q.size()),
                 64'd0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
